redmule_job_programmer: RTL and testbench
=========================================

Name: redmule_job_programmer

Overview:
- Front-end master that turns a compact GEMM job descriptor (matrix base addresses, M/N/K sizes, op word) into the 19-entry RedMulE register-file image (indices X_ADDR..OP_SELECTION).
- Writes the image into the job register file, one word per granted request.
- Sits between the software/cluster-side job queue and the register-file target port; it is the writer side of the register map the controller reads.

Parameters:
- ARRAY_WIDTH, 12, rows per X tile (from redmule_pkg)
- ARRAY_HEIGHT, 4, W rows per engine column (from redmule_pkg)
- PIPE_REGS, 3, CE pipeline depth; TILE = (PIPE_REGS+1)*ARRAY_HEIGHT = 16
- BITW, 16, element width in bits; ELEM_B = BITW/8 bytes
- N_REGS, 19, number of register words written (REDMULE_REGS)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- job_valid_i  in  1  descriptor valid
- job_ready_o  out  1  descriptor accepted (IDLE only)
- job_x_addr_i, job_w_addr_i, job_y_addr_i, job_z_addr_i  in  32 each  matrix base byte addresses
- job_m_i, job_n_i, job_k_i  in  16 each  X rows, X cols/W rows, W cols
- job_op_i  in  32  OP_SELECTION word, passed through
- reg_req_o  out  1  register write request
- reg_add_o  out  32  byte offset = index*4
- reg_wdata_o  out  32  write data
- reg_gnt_i  in  1  write grant
- busy_o  out  1  high outside IDLE
- done_o  out  1  one-cycle pulse after the last grant
- err_o  out  1  one-cycle pulse on descriptor rejection (optional feature only; tied 0 otherwise)

Behaviour:
- Reset: FSM to IDLE. job_ready_o=1, reg_req_o=0, reg_add_o=0, reg_wdata_o=0, busy_o=0, done_o=0, err_o=0.
- Reset mid-operation: abort immediately. No further requests; the partially written image is left as is.
- IDLE: job_ready_o=1. On job_valid_i, latch the descriptor and go to DIV.
- DIV: serial restoring divide of M by ARRAY_WIDTH, 16 cycles, giving q and r = M mod 12.
  - xr = q + (r!=0).
  - N/TILE and K/TILE use shifts.
  - xc = ceil(N/16), wc = ceil(K/16).
- CALC: one cycle. Registers the image; all products truncated to 32 bits.
  - 0..3: X/W/Y/Z addresses.
  - 4 X_ITERS = {xr[15:0], xc[15:0]}; 5 W_ITERS = {xc, wc}.
  - 6 LEFTOVERS = {r[7:0], N%16, N%16, K%16}.
  - 7 LEFT_PARAMS = {(xr*wc)[15:0], 1'b0, N<4, K<16, 13'b0}.
  - 8 X_D1_STRIDE = N*ELEM_B; 9 W_TOT_LEN = xr*wc*xc*TILE; 10 TOT_X_READ = xr*xc.
  - 11 W_D0_STRIDE = K*ELEM_B; 12 Z_TOT_LEN = xr*wc*ARRAY_WIDTH; 13 Z_D0_STRIDE = K*ELEM_B.
  - 14 Z_D2_STRIDE = ARRAY_WIDTH*K*ELEM_B; 15 X_ROWS_OFFS = ARRAY_WIDTH*N*ELEM_B.
  - 16 X_SLOTS = {(xr*wc)[15:0], xc[15:0]}; 17 IN_TOT_LEN = xr*xc*wc; 18 OP_SELECTION = job_op_i.
- WRITE: index counter idx from 0 to 18.
  - reg_req_o=1, reg_add_o=idx*4, reg_wdata_o=image[idx].
  - Address and data are stable while req is high and not granted.
  - On reg_gnt_i, idx increments next cycle; req stays high back-to-back, so the minimum is 19 cycles for 19 writes.
  - Grant on idx=18 goes to DONE.
- DONE: done_o=1 for one cycle, then IDLE. A new job_valid_i is accepted no earlier than the cycle after DONE.
- Minimum latency, accept to done_o: 1 + 16 + 1 + 19 + 1 = 38 cycles.
- reg_gnt_i outside WRITE is ignored.

Optional Feature:
- Macro: REDMULE_JOB_ZERO_CHECK_EN.
- Defined: in DIV's first cycle, if any of M, N, K equals 0, err_o pulses one cycle, no writes are issued, and the FSM returns to IDLE.
- Undefined: zero sizes are programmed as computed (iterations 0, strides 0) and err_o is tied 0.

Decomposition:
- Add to redmule_pkg:
  - TILE constant.
  - job_desc_t struct (addresses, m/n/k, op).
  - prog_state_e enum {IDLE, DIV, CALC, WRITE, DONE}.
  - reg_image_t = logic [N_REGS-1:0][31:0].
- One sub-module, redmule_prog_divider: 16-bit serial restoring divider with start/valid handshake, quotient and remainder.

Test Plan:
- M=24,N=32,K=16, grant always 1 -> 19 writes on consecutive cycles with:
  - X_ITERS=0x00020002, W_ITERS=0x00020001, LEFTOVERS=0x00000000.
  - X_D1_STRIDE=64, W_D0_STRIDE=32, Z_D2_STRIDE=384.
  - done_o at cycle 38.
- M=13,N=5,K=20 -> X_ITERS=0x00020001, LEFTOVERS=0x01050504, LEFT_PARAMS=0x00040000, Z_TOT_LEN=48.
- N=3,K=8,M=12 -> LEFT_PARAMS bit14=1 and bit13=1, LEFTOVERS[31:24]=0, X_ITERS[31:16]=1.
- Random grant stalls (0–5 cycles) -> reg_add_o/reg_wdata_o held while ungranted, no skipped or duplicated index, addresses 0x00..0x48 in order.
- rst_i asserted during WRITE at idx=7 -> next cycle reg_req_o=0, busy_o=0, job_ready_o=1; a fresh job then starts at idx 0.
- With REDMULE_JOB_ZERO_CHECK_EN, K=0 -> err_o single pulse, zero reg_req_o cycles, back to IDLE; without the macro, the same job writes 19 words with W_ITERS[15:0]=0.

Source files
------------

// File: rtl/redmule_pkg.sv
// redmule_pkg: shared geometry constants, job descriptor and register-image types for the RedMulE job programmer
package redmule_pkg;
    localparam int ARRAY_WIDTH  = 12;
    localparam int ARRAY_HEIGHT = 4;
    localparam int PIPE_REGS    = 3;
    localparam int BITW         = 16;
    localparam int ELEM_B       = BITW / 8;
    localparam int N_REGS       = 19;
    localparam int TILE         = (PIPE_REGS + 1) * ARRAY_HEIGHT;

    typedef struct packed {
        logic [31:0] x_addr;
        logic [31:0] w_addr;
        logic [31:0] y_addr;
        logic [31:0] z_addr;
        logic [15:0] m;
        logic [15:0] n;
        logic [15:0] k;
        logic [31:0] op;
    } job_desc_t;

    typedef enum logic [2:0] {IDLE, DIV, CALC, WRITE, DONE} prog_state_e;

    typedef logic [N_REGS-1:0][31:0] reg_image_t;
endpackage

// File: rtl/redmule_prog_divider.sv
// redmule_prog_divider: 16-bit serial restoring divider, one quotient bit per cycle over 16 cycles
module redmule_prog_divider (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_start,
    input  logic [15:0] i_dividend,
    input  logic [15:0] i_divisor,
    output logic        o_valid,
    output logic [15:0] o_quo,
    output logic [15:0] o_rem
);
    logic [4:0]  r_cnt;
    logic [15:0] r_quo, r_rem, w_src;
    logic [16:0] w_sh, w_diff;
    // dividend is sampled on the first step, so it only has to be stable the cycle after i_start
    assign w_src  = (r_cnt == 5'd16) ? i_dividend : r_quo;
    assign w_sh   = {r_rem, w_src[15]};
    assign w_diff = w_sh - {1'b0, i_divisor};
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_quo <= '0;
            r_rem <= '0;
        end else if (i_start) begin
            r_cnt <= 5'd16;
            r_rem <= '0;
        end else if (r_cnt != 5'd0) begin
            r_cnt <= r_cnt - 5'd1;
            r_rem <= w_diff[16] ? w_sh[15:0] : w_diff[15:0];
            r_quo <= {w_src[14:0], ~w_diff[16]};
        end
    end
    // o_valid marks the final step; quotient and remainder are settled from the next cycle on
    assign o_valid = (r_cnt == 5'd1);
    assign o_quo   = r_quo;
    assign o_rem   = r_rem;
endmodule

// File: rtl/redmule_job_programmer.sv
// redmule_job_programmer: expands a GEMM job descriptor into the 19-word RedMulE register image and writes it out; REDMULE_JOB_ZERO_CHECK_EN rejects zero M/N/K
module redmule_job_programmer
    import redmule_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        job_valid_i,
    output logic        job_ready_o,
    input  logic [31:0] job_x_addr_i,
    input  logic [31:0] job_w_addr_i,
    input  logic [31:0] job_y_addr_i,
    input  logic [31:0] job_z_addr_i,
    input  logic [15:0] job_m_i,
    input  logic [15:0] job_n_i,
    input  logic [15:0] job_k_i,
    input  logic [31:0] job_op_i,
    output logic        reg_req_o,
    output logic [31:0] reg_add_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_gnt_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    prog_state_e r_state, w_next;
    job_desc_t   r_job;
    reg_image_t  r_image, w_image;
    logic [4:0]  r_idx;
    logic [15:0] w_quo, w_rem;
    logic        w_div_last, w_err, w_accept;
    logic [31:0] w_xr, w_xc, w_wc, w_xrwc, w_n, w_k;

    assign w_accept = (r_state == IDLE) && job_valid_i;

    redmule_prog_divider u_div (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_start    (w_accept),
        .i_dividend (r_job.m),
        .i_divisor  (16'(ARRAY_WIDTH)),
        .o_valid    (w_div_last),
        .o_quo      (w_quo),
        .o_rem      (w_rem)
    );

`ifdef REDMULE_JOB_ZERO_CHECK_EN
    logic r_first;
    always_ff @(posedge clk_i) begin
        r_first <= rst_i ? 1'b0 : w_accept;
    end
    assign w_err = r_first && (r_job.m == 16'd0 || r_job.n == 16'd0 || r_job.k == 16'd0);
`else
    assign w_err = 1'b0;
`endif
    assign err_o = w_err;

    always_ff @(posedge clk_i) begin
        r_state <= rst_i ? IDLE : w_next;
    end

    always_comb begin
        w_next      = r_state;
        job_ready_o = 1'b0;
        busy_o      = 1'b1;
        reg_req_o   = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            IDLE: begin
                job_ready_o = 1'b1;
                busy_o      = 1'b0;
                w_next      = job_valid_i ? DIV : IDLE;
            end
            DIV:   w_next = w_err ? IDLE : (w_div_last ? CALC : DIV);
            CALC:  w_next = WRITE;
            WRITE: begin
                reg_req_o = 1'b1;
                w_next    = (reg_gnt_i && r_idx == 5'(N_REGS - 1)) ? DONE : WRITE;
            end
            DONE: begin
                done_o = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign reg_add_o   = (r_state == WRITE) ? {25'd0, r_idx, 2'b00} : '0;
    assign reg_wdata_o = (r_state == WRITE) ? r_image[r_idx] : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_job   <= '0;
            r_image <= '0;
            r_idx   <= '0;
        end else begin
            if (w_accept)
                r_job <= '{job_x_addr_i, job_w_addr_i, job_y_addr_i, job_z_addr_i,
                           job_m_i, job_n_i, job_k_i, job_op_i};
            if (r_state == CALC) begin
                r_image <= w_image;
                r_idx   <= '0;
            end else if (r_state == WRITE && reg_gnt_i) begin
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    assign w_xr   = 32'(w_quo) + 32'(w_rem != 16'd0);
    assign w_xc   = 32'(r_job.n[15:4]) + 32'(r_job.n[3:0] != 4'd0);
    assign w_wc   = 32'(r_job.k[15:4]) + 32'(r_job.k[3:0] != 4'd0);
    assign w_xrwc = w_xr * w_wc;
    assign w_n    = 32'(r_job.n);
    assign w_k    = 32'(r_job.k);

    always_comb begin
        w_image     = '0;
        w_image[0]  = r_job.x_addr;
        w_image[1]  = r_job.w_addr;
        w_image[2]  = r_job.y_addr;
        w_image[3]  = r_job.z_addr;
        w_image[4]  = {w_xr[15:0], w_xc[15:0]};
        w_image[5]  = {w_xc[15:0], w_wc[15:0]};
        w_image[6]  = {w_rem[7:0], 4'd0, r_job.n[3:0], 4'd0, r_job.n[3:0], 4'd0, r_job.k[3:0]};
        w_image[7]  = {w_xrwc[15:0], 1'b0, r_job.n < 16'd4, r_job.k < 16'd16, 13'd0};
        w_image[8]  = w_n * 32'(ELEM_B);
        w_image[9]  = w_xrwc * w_xc * 32'(TILE);
        w_image[10] = w_xr * w_xc;
        w_image[11] = w_k * 32'(ELEM_B);
        w_image[12] = w_xrwc * 32'(ARRAY_WIDTH);
        w_image[13] = w_k * 32'(ELEM_B);
        w_image[14] = w_k * 32'(ARRAY_WIDTH * ELEM_B);
        w_image[15] = w_n * 32'(ARRAY_WIDTH * ELEM_B);
        w_image[16] = {w_xrwc[15:0], w_xc[15:0]};
        w_image[17] = w_xrwc * w_xc;
        w_image[18] = r_job.op;
    end
endmodule

// File: tb/tb_redmule_job_programmer.sv
// tb_redmule_job_programmer: directed and randomized jobs checked against an arithmetic model of the register image
module tb_redmule_job_programmer;
    logic        clk_i = 1'b0, rst_i = 1'b1, job_valid_i = 1'b0, reg_gnt_i = 1'b0;
    logic [31:0] job_x_addr_i = '0, job_w_addr_i = '0, job_y_addr_i = '0, job_z_addr_i = '0, job_op_i = '0;
    logic [15:0] job_m_i = '0, job_n_i = '0, job_k_i = '0;
    logic        job_ready_o, reg_req_o, busy_o, done_o, err_o;
    logic [31:0] reg_add_o, reg_wdata_o;
    int          checks = 0, errors = 0;
    logic [31:0] exp_img [19];
    logic [31:0] dut_img [19];

    always #5 clk_i = ~clk_i;

    redmule_job_programmer dut (
        .clk_i(clk_i), .rst_i(rst_i), .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_x_addr_i(job_x_addr_i), .job_w_addr_i(job_w_addr_i), .job_y_addr_i(job_y_addr_i),
        .job_z_addr_i(job_z_addr_i), .job_m_i(job_m_i), .job_n_i(job_n_i), .job_k_i(job_k_i),
        .job_op_i(job_op_i), .reg_req_o(reg_req_o), .reg_add_o(reg_add_o), .reg_wdata_o(reg_wdata_o),
        .reg_gnt_i(reg_gnt_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, idx, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_job(input int m, input int n, input int k);
        job_m_i      = 16'(m);
        job_n_i      = 16'(n);
        job_k_i      = 16'(k);
        job_x_addr_i = $urandom;
        job_w_addr_i = $urandom;
        job_y_addr_i = $urandom;
        job_z_addr_i = $urandom;
        job_op_i     = $urandom;
    endtask

    task automatic build_model;
        longint m  = longint'(job_m_i);
        longint n  = longint'(job_n_i);
        longint k  = longint'(job_k_i);
        longint xr = (m + 11) / 12;
        longint r  = m % 12;
        longint xc = (n + 15) / 16;
        longint wc = (k + 15) / 16;
        longint xw = (xr * wc) % 65536;
        exp_img[0]  = job_x_addr_i;
        exp_img[1]  = job_w_addr_i;
        exp_img[2]  = job_y_addr_i;
        exp_img[3]  = job_z_addr_i;
        exp_img[4]  = 32'(xr * 65536 + xc);
        exp_img[5]  = 32'(xc * 65536 + wc);
        exp_img[6]  = 32'(r * 16777216 + (n % 16) * 65536 + (n % 16) * 256 + (k % 16));
        exp_img[7]  = 32'(xw * 65536 + (n < 4 ? 16384 : 0) + (k < 16 ? 8192 : 0));
        exp_img[8]  = 32'(n * 2);
        exp_img[9]  = 32'(xr * wc * xc * 16);
        exp_img[10] = 32'(xr * xc);
        exp_img[11] = 32'(k * 2);
        exp_img[12] = 32'(xr * wc * 12);
        exp_img[13] = 32'(k * 2);
        exp_img[14] = 32'(24 * k);
        exp_img[15] = 32'(24 * n);
        exp_img[16] = 32'(xw * 65536 + xc);
        exp_img[17] = 32'(xr * xc * wc);
        exp_img[18] = job_op_i;
    endtask

    task automatic run_job(input int max_stall, input int exp_lat, input int exp_writes);
        int cyc, nw, stall;
        build_model;
        chk("ready_idle", 0, 32'(job_ready_o), 1);
        job_valid_i = 1'b1;
        tick;
        job_valid_i = 1'b0;
        chk("busy_after_accept", 0, 32'(busy_o), 1);
        cyc   = 2;
        nw    = 0;
        stall = $urandom_range(0, max_stall);
        while (!done_o && cyc < 400) begin
            if (reg_req_o) begin
                chk("write_in_range", nw, 32'(nw < 19), 1);
                if (nw < 19) begin
                    chk("reg_add", nw, reg_add_o, 32'(nw * 4));
                    chk("reg_wdata", nw, reg_wdata_o, exp_img[nw]);
                end
                if (stall == 0) begin
                    reg_gnt_i = 1'b1;
                    if (nw < 19) dut_img[nw] = reg_wdata_o;
                    nw++;
                    stall = $urandom_range(0, max_stall);
                end else begin
                    reg_gnt_i = 1'b0;
                    stall--;
                end
            end else begin
                reg_gnt_i = 1'($urandom_range(0, 1));
            end
            tick;
            cyc++;
        end
        reg_gnt_i = 1'b0;
        chk("done_seen", 0, 32'(done_o), 1);
        chk("ready_in_done", 0, 32'(job_ready_o), 0);
        chk("n_writes", 0, 32'(nw), 32'(exp_writes));
        if (exp_lat > 0) chk("latency", 0, 32'(cyc), 32'(exp_lat));
        tick;
        chk("done_pulse_end", 0, 32'(done_o), 0);
        chk("ready_after_done", 0, 32'(job_ready_o), 1);
        chk("busy_after_done", 0, 32'(busy_o), 0);
    endtask

    initial begin
        int cyc;
`ifdef REDMULE_JOB_ZERO_CHECK_EN
        int nerr, nreq;
`endif
        repeat (3) tick;
        chk("rst_ready", 0, 32'(job_ready_o), 1);
        chk("rst_req", 0, 32'(reg_req_o), 0);
        chk("rst_add", 0, reg_add_o, 0);
        chk("rst_wdata", 0, reg_wdata_o, 0);
        chk("rst_busy", 0, 32'(busy_o), 0);
        chk("rst_done", 0, 32'(done_o), 0);
        chk("rst_err", 0, 32'(err_o), 0);
        rst_i = 1'b0;
        tick;

        set_job(24, 32, 16);
        run_job(0, 38, 19);
        chk("x_iters_a", 0, dut_img[4], 32'h00020002);
        chk("w_iters_a", 0, dut_img[5], 32'h00020001);
        chk("leftovers_a", 0, dut_img[6], 32'h00000000);
        chk("x_d1_stride_a", 0, dut_img[8], 32'd64);
        chk("w_d0_stride_a", 0, dut_img[11], 32'd32);
        chk("z_d2_stride_a", 0, dut_img[14], 32'd384);

        set_job(13, 5, 20);
        run_job(0, 38, 19);
        chk("x_iters_b", 0, dut_img[4], 32'h00020001);
        chk("leftovers_b", 0, dut_img[6], 32'h01050504);
        chk("left_params_b", 0, dut_img[7], 32'h00040000);
        chk("z_tot_len_b", 0, dut_img[12], 32'd48);

        set_job(12, 3, 8);
        run_job(2, 0, 19);
        chk("left_params_c_b14", 0, 32'(dut_img[7][14]), 1);
        chk("left_params_c_b13", 0, 32'(dut_img[7][13]), 1);
        chk("leftovers_c_hi", 0, 32'(dut_img[6][31:24]), 0);
        chk("x_iters_c_hi", 0, 32'(dut_img[4][31:16]), 1);

        for (int i = 0; i < 4; i++) begin
            set_job($urandom_range(1, 3000), $urandom_range(1, 3000), $urandom_range(1, 3000));
            run_job(5, 0, 19);
        end

        set_job(40, 40, 40);
        job_valid_i = 1'b1;
        tick;
        job_valid_i = 1'b0;
        reg_gnt_i   = 1'b1;
        cyc = 0;
        while (!(reg_req_o && reg_add_o == 32'd28) && cyc < 100) begin
            tick;
            cyc++;
        end
        chk("reach_idx7", 0, reg_add_o, 32'd28);
        rst_i     = 1'b1;
        reg_gnt_i = 1'b0;
        tick;
        chk("rst_mid_req", 0, 32'(reg_req_o), 0);
        chk("rst_mid_busy", 0, 32'(busy_o), 0);
        chk("rst_mid_ready", 0, 32'(job_ready_o), 1);
        rst_i = 1'b0;
        tick;
        set_job(100, 50, 70);
        run_job(3, 0, 19);

        set_job(30, 20, 0);
`ifdef REDMULE_JOB_ZERO_CHECK_EN
        job_valid_i = 1'b1;
        tick;
        job_valid_i = 1'b0;
        chk("err_first_div", 0, 32'(err_o), 1);
        nerr = 1;
        nreq = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            nerr += int'(err_o);
            nreq += int'(reg_req_o);
        end
        chk("err_pulses", 0, 32'(nerr), 1);
        chk("err_no_req", 0, 32'(nreq), 0);
        chk("err_back_idle", 0, 32'(job_ready_o), 1);
`else
        run_job(1, 0, 19);
        chk("k0_w_iters_lo", 0, 32'(dut_img[5][15:0]), 0);
        chk("k0_err_low", 0, 32'(err_o), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
